// File: rtl/alu_seq_core_if.sv
// -----------------------------------------------------------------------------
// alu_seq_core_if
// Handshake bundle between the operand/opcode capture logic (master) and the
// sequential ALU core (slave).
//   in_valid / in_ready   : operation request handshake
//   A, B                  : WIDTH-bit unsigned operands
//   Opcode                : 4-bit operation select
//   out_valid / out_ready : result handshake
//   result                : 2*WIDTH-bit result
//   overflow, div_zero,
//   bad_op                : status flags, meaningful while out_valid=1
//   busy                  : core is iterating a multiply or divide
// -----------------------------------------------------------------------------
interface alu_seq_core_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [3:0]           Opcode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 overflow;
    logic                 div_zero;
    logic                 bad_op;
    logic                 busy;

    modport master (
        output in_valid, A, B, Opcode, out_ready,
        input  in_ready, out_valid, result, overflow, div_zero, bad_op, busy
    );

    modport slave (
        input  in_valid, A, B, Opcode, out_ready,
        output in_ready, out_valid, result, overflow, div_zero, bad_op, busy
    );
endinterface

// File: rtl/alu_seq_core.sv
// -----------------------------------------------------------------------------
// alu_seq_core
// Handshaked, parametrised ALU. Single-cycle ops (ADD, SUB, logic, shifts,
// DIV by zero, unsupported opcodes) complete at the accept edge; MUL runs a
// shift-add loop and DIV (B!=0) a restoring-divide loop, one step per clock
// for WIDTH clocks. One operation is in flight at a time.
//
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset (0 = reset asserted)
//   acc_sel : (ALU_ACC_MODE_EN only) take operand A from the accumulator
//   bus     : alu_seq_core_if.slave handshake/data bundle
//
// Optional feature macro: ALU_ACC_MODE_EN
//   When defined, a WIDTH-bit accumulator captures result[WIDTH-1:0] on every
//   result handshake and can replace A at accept time via acc_sel.
// -----------------------------------------------------------------------------
module alu_seq_core #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
`ifdef ALU_ACC_MODE_EN
    input  logic          acc_sel,
`endif
    alu_seq_core_if.slave bus
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WMOD     = WIDTH[WIDTH-1:0];

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [W2-1:0] res;
        logic          ov;
        logic          dz;
        logic          bad;
    } op_out_t;

    // Result and flags for every operation that completes at the accept edge.
    // MUL and DIV with a non-zero divisor return zeros here; the iteration
    // loop builds their result starting from that cleared value.
    function automatic op_out_t single_op(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [3:0]       op
    );
        op_out_t          o;
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   diff;
        logic [WIDTH-1:0] shamt;
        logic [W2-1:0]    ax;
        o     = '0;
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        shamt = b % WMOD;
        ax    = {{WIDTH{1'b0}}, a};
        case (op)
            OP_ADD: begin
                o.res = {{(WIDTH-1){1'b0}}, sum};
                o.ov  = sum[WIDTH];
            end
            OP_SUB: begin
                o.res = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                o.ov  = diff[WIDTH];
            end
            OP_MUL: o.res = '0;
            OP_DIV: begin
                if (b == '0) begin
                    o.res = {a, {WIDTH{1'b1}}};
                    o.dz  = 1'b1;
                end
            end
            OP_AND: o.res = {{WIDTH{1'b0}}, a & b};
            OP_OR:  o.res = {{WIDTH{1'b0}}, a | b};
            OP_XOR: o.res = {{WIDTH{1'b0}}, a ^ b};
            OP_NOT: o.res = {{WIDTH{1'b0}}, ~a};
            OP_SHL: begin
                o.res = ax << shamt;
                o.ov  = |o.res[W2-1:WIDTH];
            end
            OP_SHR: o.res = ax >> shamt;
            default: o.bad = 1'b1;
        endcase
        return o;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_eff;
    logic             accept;
    op_out_t          single;

    logic [W2-1:0]    result_q;
    logic             ov_q, dz_q, bad_q;
    logic [W2-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

`ifdef ALU_ACC_MODE_EN
    logic [WIDTH-1:0] acc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (state_q == DONE && bus.out_ready) begin
            acc_q <= result_q[WIDTH-1:0];
        end
    end

    assign a_eff = acc_sel ? acc_q : bus.A;
`else
    assign a_eff = bus.A;
`endif

    assign accept = (state_q == IDLE) && bus.in_valid;
    assign single = single_op(a_eff, bus.B, bus.Opcode);

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder, subtract the divisor if it fits. The partial
    // remainder is always below the divisor, so WIDTH+1 bits hold the shift.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        ge     = rem_sh >= {1'b0, dvsr_q};
        rem_nx = ge ? WIDTH'(rem_sh - {1'b0, dvsr_q}) : rem_sh[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.Opcode == OP_MUL) begin
                        state_d = MUL;
                    end else if (bus.Opcode == OP_DIV && bus.B != '0) begin
                        state_d = DIV;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            MUL:  if (cnt_q == '0) state_d = DONE;
            DIV:  if (cnt_q == '0) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            ov_q     <= 1'b0;
            dz_q     <= 1'b0;
            bad_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        result_q <= single.res;
                        ov_q     <= single.ov;
                        dz_q     <= single.dz;
                        bad_q    <= single.bad;
                        mcand_q  <= {{WIDTH{1'b0}}, a_eff};
                        mplier_q <= bus.B;
                        dvsr_q   <= bus.B;
                        rem_q    <= '0;
                        quo_q    <= a_eff;
                        cnt_q    <= CNT_INIT;
                    end
                end
                MUL: begin
                    if (mplier_q[0]) begin
                        result_q <= result_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                end
                DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        result_q <= {rem_nx, quo_nx};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == MUL) || (state_q == DIV);
    assign bus.result    = result_q;
    assign bus.overflow  = ov_q;
    assign bus.div_zero  = dz_q;
    assign bus.bad_op    = bad_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_core
// Bench for alu_seq_core at WIDTH=4: directed operations with literal
// expectations, a reset abort mid-multiply, back-pressure, and a randomized
// operation stream compared against an arithmetic reference model.
// Define ALU_ACC_MODE_EN to exercise the accumulator variant.
// -----------------------------------------------------------------------------
module tb_alu_seq_core;

    localparam int WIDTH = 4;
    localparam int W2    = 2 * WIDTH;

    logic clk = 1'b0;
    logic reset;
`ifdef ALU_ACC_MODE_EN
    logic acc_sel;
`endif

    always #5 clk = ~clk;

    alu_seq_core_if #(.WIDTH(WIDTH)) bus ();

    alu_seq_core #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef ALU_ACC_MODE_EN
        .acc_sel(acc_sel),
`endif
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [W2-1:0] exp_res;
    logic          exp_ov, exp_dz, exp_bad;
    logic          exp_armed = 1'b0;
    int unsigned   acc_model = 0;

    logic [W2-1:0] o_res;
    logic          o_ov, o_dz, o_bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {result, overflow, div_zero, bad_op} from plain arithmetic.
    function automatic logic [W2+2:0] model(input int unsigned a, input int unsigned b,
                                            input int unsigned op);
        longint unsigned r;
        logic            ov, dz, bad;
        int unsigned     mask;
        int unsigned     sh;
        r = 0; ov = 1'b0; dz = 1'b0; bad = 1'b0;
        mask = (1 << WIDTH) - 1;
        sh = b % WIDTH;
        case (op)
            0: begin r = a + b; ov = (r >> WIDTH) != 0; end
            1: begin r = (a - b) & mask; ov = (a < b); end
            2: r = a * b;
            3: begin
                if (b == 0) begin
                    r = (a << WIDTH) | mask;
                    dz = 1'b1;
                end else begin
                    r = ((a % b) << WIDTH) | (a / b);
                end
            end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: r = (~a) & mask;
            8: begin r = a << sh; ov = (r >> WIDTH) != 0; end
            9: r = a >> sh;
            default: bad = 1'b1;
        endcase
        return {r[W2-1:0], ov, dz, bad};
    endfunction

    // Result-side checker: whenever the core presents a result it must match
    // the operation most recently issued.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.out_valid === 1'b1) begin
            check("valid_expected", exp_armed, 1);
            check("result", bus.result, exp_res);
            check("overflow", bus.overflow, exp_ov);
            check("div_zero", bus.div_zero, exp_dz);
            check("bad_op", bus.bad_op, exp_bad);
            check("busy_in_done", bus.busy, 0);
            check("in_ready_in_done", bus.in_ready, 0);
        end
    end

    task automatic run_op(input int unsigned a, input int unsigned b, input int unsigned op,
                          input bit sel, input int hold,
                          output logic [W2-1:0] r_res, output logic r_ov,
                          output logic r_dz, output logic r_bad);
        int          cycles;
        int          lat;
        int unsigned a_eff;
        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1);
        a_eff = a;
`ifdef ALU_ACC_MODE_EN
        acc_sel = sel;
        if (sel) a_eff = acc_model;
`else
        if (sel) a_eff = a;
`endif
        {exp_res, exp_ov, exp_dz, exp_bad} = model(a_eff, b, op);
        exp_armed = 1'b1;
        lat = (op == 2 || (op == 3 && b != 0)) ? WIDTH : 0;
        bus.A      = WIDTH'(a);
        bus.B      = WIDTH'(b);
        bus.Opcode = 4'(op);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.A      = WIDTH'($urandom);
        bus.B      = WIDTH'($urandom);
        bus.Opcode = 4'($urandom);
`ifdef ALU_ACC_MODE_EN
        acc_sel = 1'($urandom);
`endif
        cycles = 0;
        while (!bus.out_valid && cycles < 40) begin
            check("busy_iter", bus.busy, 1);
            check("in_ready_iter", bus.in_ready, 0);
            @(posedge clk); #1;
            cycles++;
        end
        check("latency", cycles, lat);
        r_res = bus.result;
        r_ov  = bus.overflow;
        r_dz  = bus.div_zero;
        r_bad = bus.bad_op;
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", bus.out_valid, 1);
            check("hold_result", bus.result, r_res);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        exp_armed = 1'b0;
        acc_model = exp_res[WIDTH-1:0];
        check("valid_drop", bus.out_valid, 0);
        check("back_to_idle", bus.in_ready, 1);
    endtask

    initial begin
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.Opcode   = '0;
`ifdef ALU_ACC_MODE_EN
        acc_sel      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_result", bus.result, 0);
        check("rst_flags", {bus.overflow, bus.div_zero, bus.bad_op}, 0);
        reset = 1'b1;

        run_op(10, 10, 0, 1'b0, 0, o_res, o_ov, o_dz, o_bad);
        check("add_lit_res", o_res, 8'h14);
        check("add_lit_ov", o_ov, 1);

        run_op(3, 8, 2, 1'b0, 0, o_res, o_ov, o_dz, o_bad);
        check("mul_lit_res", o_res, 8'h18);

        run_op(13, 4, 3, 1'b0, 0, o_res, o_ov, o_dz, o_bad);
        check("div_lit_res", o_res, 8'h13);

        run_op(6, 0, 3, 1'b0, 0, o_res, o_ov, o_dz, o_bad);
        check("div0_lit_res", o_res, 8'h6F);
        check("div0_lit_dz", o_dz, 1);

        run_op(3, 8, 1, 1'b0, 6, o_res, o_ov, o_dz, o_bad);
        check("sub_lit_res", o_res, 8'h0B);
        check("sub_lit_ov", o_ov, 1);

        run_op(9, 3, 8, 1'b0, 1, o_res, o_ov, o_dz, o_bad);
        check("shl_lit_res", o_res, 8'h48);
        check("shl_lit_ov", o_ov, 1);

        run_op(5, 5, 12, 1'b0, 0, o_res, o_ov, o_dz, o_bad);
        check("bad_lit_res", o_res, 0);
        check("bad_lit_flag", o_bad, 1);

        // Reset two cycles into a multiply abandons it immediately.
        @(negedge clk);
        bus.A = 4'd3; bus.B = 4'd8; bus.Opcode = 4'd2; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_before", bus.busy, 1);
        reset = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_result", bus.result, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_in_ready", bus.in_ready, 1);
        acc_model = 0;
        @(negedge clk);
        reset = 1'b1;

        run_op(7, 6, 0, 1'b0, 0, o_res, o_ov, o_dz, o_bad);
        check("post_rst_add", o_res, 8'h0D);

`ifdef ALU_ACC_MODE_EN
        run_op(5, 3, 0, 1'b0, 0, o_res, o_ov, o_dz, o_bad);
        check("acc_add_res", o_res, 8'h08);
        run_op(15, 2, 0, 1'b1, 0, o_res, o_ov, o_dz, o_bad);
        check("acc_sel_res", o_res, 8'h0A);
        run_op(5, 3, 12, 1'b0, 0, o_res, o_ov, o_dz, o_bad);
        check("acc_bad_res", o_res, 0);
        check("acc_bad_flag", o_bad, 1);
`endif

        for (int i = 0; i < 80; i++) begin
            int unsigned ra, rb, rop;
            bit          rsel;
            ra   = $urandom_range(0, 15);
            rb   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 15);
            rop  = $urandom_range(0, 15);
            rsel = 1'($urandom);
            run_op(ra, rb, rop, rsel, $urandom_range(0, 3), o_res, o_ov, o_dz, o_bad);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
